if_fetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage.
- Generates the instruction-fetch PC and drives a synchronous instruction ROM with 1-cycle read latency.
- Buffers fetched instruction/PC pairs in a small FIFO so the ID stage can back-pressure without losing fetches.
- Supports stall, jump/branch redirect with wrong-path squash, a configurable reset vector and a configurable PC step.

---
 rtl/if_fetch_queue.sv | 118 +++++++++++
 tb/tb_if_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC generation, 1-cycle ROM issue and a small credit-limited FIFO toward ID.
// Optional: define IF_MISALIGN_CHECK_EN to word-align redirect targets and flag misaligned jumps.
module if_fetch_queue #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] inst_in,
    input  logic              jCe,
    input  logic [ADDR_W-1:0] jAddr,
    input  logic              stall,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic                  running_q;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_W-1:0]     ifl_pc_q, ifl_pc_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0]      occ;
    logic [PTR_W:0]        count;
    logic                  empty, push, pop;
    logic [ADDR_W-1:0]     target;

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] inst_mem_q;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] pc_mem_q;

    assign empty = (wptr_q == rptr_q);
    assign occ   = wptr_q - rptr_q;
    // Credits cover the in-flight fetch so a return always has a free slot.
    assign count = {1'b0, occ} + {{PTR_W{1'b0}}, inflight_q};
    assign ce    = running_q & ~stall & ~jCe & (count < DEPTH_C);
    assign pc    = pc_q;

    assign id_valid = ~empty;
    assign id_inst  = empty ? '0 : inst_mem_q[rptr_q[IDX_W-1:0]];
    assign id_pc    = empty ? '0 : pc_mem_q[rptr_q[IDX_W-1:0]];

    assign push = inflight_q & ~jCe;
    assign pop  = id_valid & id_ready & ~jCe;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;
    assign target   = {jAddr[ADDR_W-1:2], 2'b00};
    assign misalign = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= jCe & (jAddr[1:0] != 2'b00);
    end
`else
    assign target = jAddr;
`endif

    always_comb begin
        pc_d       = pc_q;
        inflight_d = ce;
        ifl_pc_d   = ifl_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (jCe) begin
            pc_d   = target;
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (ce) begin
                pc_d     = pc_q + ADDR_W'(PC_STEP);
                ifl_pc_d = pc_q;
            end
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_q  <= 1'b0;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            ifl_pc_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            running_q  <= 1'b1;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            ifl_pc_q   <= ifl_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset: reads of an empty queue are masked to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wptr_q[IDX_W-1:0]] <= inst_in;
            pc_mem_q[wptr_q[IDX_W-1:0]]   <= ifl_pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: flow, back-pressure, redirect, stall, async reset, wrap.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic        jCe;
    logic [31:0] jAddr;
    logic        stall;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    if_fetch_queue dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .pc       (pc),
        .inst_in  (inst_in),
        .jCe      (jCe),
        .jAddr    (jAddr),
        .stall    (stall),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_inst  (id_inst),
        .id_pc    (id_pc)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .misalign (misalign)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: data for the issued address appears one cycle later.
    always @(posedge clk) begin
        if (ce) inst_in <= pc + 32'h100;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; jCe = 1'b0; jAddr = '0; stall = 1'b0; id_ready = 1'b1; inst_in = '0;
        #2;
        check("rst_ce", ce, 0);
        check("rst_pc", pc, 0);
        check("rst_valid", id_valid, 0);
        check("rst_inst", id_inst, 0);
        check("rst_idpc", id_pc, 0);

        // Flow: one instruction per cycle
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ce_before_run", ce, 0);
        step();
        check("run_ce", ce, 1);
        check("run_pc0", pc, 32'h0);
        check("run_valid0", id_valid, 0);
        step();
        check("flow_pc4", pc, 32'h4);
        check("flow_valid_lat", id_valid, 0);
        step();
        check("flow_pc8", pc, 32'h8);
        check("flow_v", id_valid, 1);
        check("flow_idpc0", id_pc, 32'h0);
        check("flow_inst0", id_inst, 32'h100);
        step();
        check("flow_pcC", pc, 32'hC);
        check("flow_idpc4", id_pc, 32'h4);
        check("flow_inst4", id_inst, 32'h104);
        step();
        check("flow_pc10", pc, 32'h10);
        check("flow_idpc8", id_pc, 32'h8);
        check("flow_inst8", id_inst, 32'h108);

        // Asynchronous reset between edges
        rst = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_valid", id_valid, 0);
        check("async_ce", ce, 0);
        id_ready = 1'b0;
        #1;
        rst = 1'b1;

        // Back-pressure: exactly FIFO_DEPTH pushes then freeze
        step();
        check("bp_ce_start", ce, 1);
        step();
        step();
        step();
        step();
        check("bp_pc10", pc, 32'h10);
        check("bp_ce_credit", ce, 0);
        step();
        check("bp_ce_full", ce, 0);
        check("bp_valid", id_valid, 1);
        check("bp_head0", id_pc, 32'h0);
        step();
        check("bp_frozen_pc", pc, 32'h10);
        check("bp_frozen_ce", ce, 0);
        id_ready = 1'b1;
        step();
        check("drain_idpc4", id_pc, 32'h4);
        check("drain_ce", ce, 1);
        check("drain_pc", pc, 32'h10);
        step();
        check("drain_idpc8", id_pc, 32'h8);
        check("drain_pc14", pc, 32'h14);
        step();
        check("drain_idpcC", id_pc, 32'hC);
        step();
        check("resume_idpc10", id_pc, 32'h10);
        check("resume_inst10", id_inst, 32'h110);

        // Redirect with 2 queued entries and one in flight
        jCe = 1'b1; jAddr = 32'h200;
        #1;
        check("redir_ce0", ce, 0);
        step();
        check("redir_valid", id_valid, 0);
        check("redir_pc", pc, 32'h200);
        jCe = 1'b0;
        #1;
        check("redir_ce1", ce, 1);
        step();
        check("redir_nostale", id_valid, 0);
        step();
        check("redir_head_v", id_valid, 1);
        check("redir_head_pc", id_pc, 32'h200);
        check("redir_head_inst", id_inst, 32'h300);

        // Stall for 3 edges: in-flight still delivered, pc holds
        stall = 1'b1;
        #1;
        check("stall_ce", ce, 0);
        step();
        check("stall_deliver", id_pc, 32'h204);
        check("stall_pc1", pc, 32'h208);
        step();
        check("stall_empty", id_valid, 0);
        step();
        check("stall_pc3", pc, 32'h208);
        stall = 1'b0;
        step();
        check("unstall_pc", pc, 32'h20C);
        step();
        check("unstall_idpc", id_pc, 32'h208);
        check("unstall_inst", id_inst, 32'h308);

        // Misaligned redirect target
        jCe = 1'b1; jAddr = 32'h203;
        step();
        jCe = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        check("mis_pc", pc, 32'h200);
        check("mis_flag", misalign, 1);
        step();
        check("mis_flag_clr", misalign, 0);
        check("mis_pc_next", pc, 32'h204);
`else
        check("mis_pc", pc, 32'h203);
        step();
        check("mis_pc_next", pc, 32'h207);
`endif

        // Redirect under stall, then wrap past the top address
        jCe = 1'b1; stall = 1'b1; jAddr = 32'hFFFF_FFFC;
        step();
        jCe = 1'b0;
        #1;
        check("jstall_pc", pc, 32'hFFFF_FFFC);
        check("jstall_ce", ce, 0);
        step();
        check("jstall_hold", pc, 32'hFFFF_FFFC);
        stall = 1'b0;
        step();
        check("wrap_pc", pc, 32'h0);
        step();
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        check("wrap_inst", id_inst, 32'h0000_00FC);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
